// File: rtl/rift_core_mini.sv
// rift_core_mini: single-cycle in-order RV64I core with private ITCM and DTCM.
// Optional machine CSRs, MRET and interrupt entry are built when RIFT_IRQ_EN is defined.
module rift_core_mini #(
  parameter logic [63:0] RESET_PC  = 64'h8000_0000,
  parameter int unsigned ITCM_DP   = 4096,
  parameter logic [63:0] DTCM_BASE = 64'h8000_2000,
  parameter int unsigned DTCM_DP   = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        isExternInterrupt,
  input  logic        isRTimerInterrupt,
  input  logic        isSoftwvInterrupt,
  output logic        isEcall,
  output logic [63:0] gp
);
  localparam int unsigned IAW = $clog2(ITCM_DP);
  localparam int unsigned DAW = $clog2(DTCM_DP);

  logic [31:0] ramEve [0:ITCM_DP-1];
  logic [31:0] ramOdd [0:ITCM_DP-1];

  logic [63:0] pc_q, pc_d, rd_val;
  logic [63:0] rf_q [0:31];
  logic        halted_q, rd_we, st_req, ecall;

  logic [31:0] instr;
  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic        alt;
  logic [63:0] rs1v, rs2v, imm_i, imm_s, imm_b, imm_u, imm_j;

  assign instr = pc_q[2] ? ramOdd[pc_q[IAW+2:3]] : ramEve[pc_q[IAW+2:3]];
  assign opc   = instr[6:0];
  assign rd    = instr[11:7];
  assign f3    = instr[14:12];
  assign rs1   = instr[19:15];
  assign rs2   = instr[24:20];
  assign rs1v  = rf_q[rs1];
  assign rs2v  = rf_q[rs2];
  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  // Bit 30 selects sub/sra, except that addi/addiw have no alternate form.
  assign alt   = instr[30] & (opc[5] | (f3 == 3'b101));

  function automatic logic [63:0] alu(input logic [2:0] fn, input logic sub_sra, input logic word,
                                      input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    logic [5:0]  sh;
    sh = word ? {1'b0, b[4:0]} : b[5:0];
    case (fn)
      3'b000:  r = sub_sra ? a - b : a + b;
      3'b001:  r = a << sh;
      3'b010:  r = {63'b0, $signed(a) < $signed(b)};
      3'b011:  r = {63'b0, a < b};
      3'b100:  r = a ^ b;
      3'b101: begin
        if (word && sub_sra)  r = $signed({{32{a[31]}}, a[31:0]}) >>> sh;
        else if (word)        r = {32'b0, a[31:0]} >> sh;
        else if (sub_sra)     r = $signed(a) >>> sh;
        else                  r = a >> sh;
      end
      3'b110:  r = a | b;
      default: r = a & b;
    endcase
    if (word) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  // Data TCM: two interleaved 64-bit banks selected by offset bit 3.
  logic [63:0]    dm_addr, dm_off, dm_word, dm_rdata, ld_val, st_data, rdata_a, rdata_b;
  logic [DAW-1:0] dm_idx;
  logic [7:0]     st_mask, st_be;
  logic           dm_hit, st_we, br_taken;

  assign dm_addr  = rs1v + ((opc == 7'b0100011) ? imm_s : imm_i);
  assign dm_off   = dm_addr - DTCM_BASE;
  assign dm_hit   = (dm_addr >= DTCM_BASE) && (dm_off < 64'(DTCM_DP) * 64'd16);
  assign dm_idx   = dm_off[DAW+3:4];
  assign dm_word  = dm_off[3] ? rdata_b : rdata_a;
  assign dm_rdata = dm_hit ? (dm_word >> {dm_off[2:0], 3'b000}) : '0;
  assign st_data  = rs2v << {dm_off[2:0], 3'b000};
  assign st_mask  = (f3[1:0] == 2'b00) ? 8'h01 : (f3[1:0] == 2'b01) ? 8'h03 :
                    (f3[1:0] == 2'b10) ? 8'h0F : 8'hFF;
  assign st_be    = st_mask << dm_off[2:0];
  assign st_we    = st_req & dm_hit & ~halted_q & ~RST;

  if (1) begin : i_dtcm_A
    logic [63:0] ram [0:DTCM_DP-1];
    assign rdata_a = ram[dm_idx];
    always_ff @(posedge CLK) begin
      for (int k = 0; k < 8; k++) begin
        if (st_we && !dm_off[3] && st_be[k]) ram[dm_idx][k*8 +: 8] <= st_data[k*8 +: 8];
      end
    end
  end

  if (1) begin : i_dtcm_B
    logic [63:0] ram [0:DTCM_DP-1];
    assign rdata_b = ram[dm_idx];
    always_ff @(posedge CLK) begin
      for (int k = 0; k < 8; k++) begin
        if (st_we && dm_off[3] && st_be[k]) ram[dm_idx][k*8 +: 8] <= st_data[k*8 +: 8];
      end
    end
  end

  always_comb begin
    case (f3)
      3'b000:  ld_val = {{56{dm_rdata[7]}}, dm_rdata[7:0]};
      3'b001:  ld_val = {{48{dm_rdata[15]}}, dm_rdata[15:0]};
      3'b010:  ld_val = {{32{dm_rdata[31]}}, dm_rdata[31:0]};
      3'b100:  ld_val = {56'b0, dm_rdata[7:0]};
      3'b101:  ld_val = {48'b0, dm_rdata[15:0]};
      3'b110:  ld_val = {32'b0, dm_rdata[31:0]};
      default: ld_val = dm_rdata;
    endcase
    case (f3)
      3'b000:  br_taken = rs1v == rs2v;
      3'b001:  br_taken = rs1v != rs2v;
      3'b100:  br_taken = $signed(rs1v) < $signed(rs2v);
      3'b101:  br_taken = $signed(rs1v) >= $signed(rs2v);
      3'b110:  br_taken = rs1v < rs2v;
      3'b111:  br_taken = rs1v >= rs2v;
      default: br_taken = 1'b0;
    endcase
  end

`ifdef RIFT_IRQ_EN
  logic        mstatus_mie_q, mstatus_mpie_q, mie_meie_q, mie_mtie_q, mie_msie_q;
  logic [63:0] mtvec_q, mepc_q, mcause_q, csr_old, csr_src, csr_new, irq_cause;
  logic        irq_take, is_csr, is_mret;

  always_comb begin
    case (instr[31:20])
      12'h300: csr_old = {56'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
      12'h304: csr_old = {52'b0, mie_meie_q, 3'b0, mie_mtie_q, 3'b0, mie_msie_q, 3'b0};
      12'h305: csr_old = mtvec_q;
      12'h341: csr_old = mepc_q;
      12'h342: csr_old = mcause_q;
      12'h344: csr_old = {52'b0, isExternInterrupt, 3'b0, isRTimerInterrupt, 3'b0,
                          isSoftwvInterrupt, 3'b0};
      default: csr_old = '0;
    endcase
    csr_src = f3[2] ? {59'b0, rs1} : rs1v;
    case (f3[1:0])
      2'b01:   csr_new = csr_src;
      2'b10:   csr_new = csr_old | csr_src;
      default: csr_new = csr_old & ~csr_src;
    endcase
    irq_take  = 1'b0;
    irq_cause = '0;
    if (!halted_q && mstatus_mie_q) begin
      if (isExternInterrupt && mie_meie_q) begin
        irq_take  = 1'b1;
        irq_cause = {1'b1, 59'b0, 4'd11};
      end else if (isSoftwvInterrupt && mie_msie_q) begin
        irq_take  = 1'b1;
        irq_cause = {1'b1, 59'b0, 4'd3};
      end else if (isRTimerInterrupt && mie_mtie_q) begin
        irq_take  = 1'b1;
        irq_cause = {1'b1, 59'b0, 4'd7};
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      {mstatus_mie_q, mstatus_mpie_q, mie_meie_q, mie_mtie_q, mie_msie_q} <= '0;
      mtvec_q  <= '0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (!halted_q) begin
      if (irq_take) begin
        mepc_q         <= pc_q;
        mcause_q       <= irq_cause;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (is_mret) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end else if (is_csr) begin
        case (instr[31:20])
          12'h300: {mstatus_mpie_q, mstatus_mie_q} <= {csr_new[7], csr_new[3]};
          12'h304: {mie_meie_q, mie_mtie_q, mie_msie_q} <= {csr_new[11], csr_new[7], csr_new[3]};
          12'h305: mtvec_q  <= {csr_new[63:2], 2'b00};
          12'h341: mepc_q   <= csr_new;
          12'h342: mcause_q <= csr_new;
          default: ;
        endcase
      end
    end
  end
`else
  logic unused_irq;
  assign unused_irq = isExternInterrupt ^ isRTimerInterrupt ^ isSoftwvInterrupt;
`endif

  always_comb begin
    pc_d   = pc_q + 64'd4;
    rd_we  = 1'b0;
    rd_val = '0;
    st_req = 1'b0;
    ecall  = 1'b0;
`ifdef RIFT_IRQ_EN
    is_csr  = 1'b0;
    is_mret = 1'b0;
`endif
    case (opc)
      7'b0110111: begin rd_we = 1'b1; rd_val = imm_u; end
      7'b0010111: begin rd_we = 1'b1; rd_val = pc_q + imm_u; end
      7'b1101111: begin rd_we = 1'b1; rd_val = pc_q + 64'd4; pc_d = pc_q + imm_j; end
      7'b1100111: begin
        rd_we  = 1'b1;
        rd_val = pc_q + 64'd4;
        pc_d   = (rs1v + imm_i) & ~64'd1;
      end
      7'b1100011: if (br_taken) pc_d = pc_q + imm_b;
      7'b0000011: begin rd_we = 1'b1; rd_val = ld_val; end
      7'b0100011: st_req = 1'b1;
      7'b0010011: begin rd_we = 1'b1; rd_val = alu(f3, alt, 1'b0, rs1v, imm_i); end
      7'b0110011: begin rd_we = 1'b1; rd_val = alu(f3, alt, 1'b0, rs1v, rs2v); end
      7'b0011011: begin rd_we = 1'b1; rd_val = alu(f3, alt, 1'b1, rs1v, imm_i); end
      7'b0111011: begin rd_we = 1'b1; rd_val = alu(f3, alt, 1'b1, rs1v, rs2v); end
      7'b1110011: begin
        // ECALL holds pc so the halted core stays parked on it.
        if (instr == 32'h0000_0073) begin ecall = 1'b1; pc_d = pc_q; end
`ifdef RIFT_IRQ_EN
        else if (instr == 32'h3020_0073) begin is_mret = 1'b1; pc_d = mepc_q; end
        else if (f3 != 3'b000) begin is_csr = 1'b1; rd_we = 1'b1; rd_val = csr_old; end
`endif
      end
      default: ;
    endcase
`ifdef RIFT_IRQ_EN
    if (irq_take) begin
      pc_d    = mtvec_q;
      rd_we   = 1'b0;
      st_req  = 1'b0;
      ecall   = 1'b0;
      is_csr  = 1'b0;
      is_mret = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (!halted_q) begin
      pc_q <= pc_d;
      if (rd_we && rd != 5'd0) rf_q[rd] <= rd_val;
      if (ecall) halted_q <= 1'b1;
    end
  end

  assign isEcall = ecall & ~halted_q & ~RST;
  assign gp      = rf_q[3];
endmodule

// File: tb/tb_rift_core_mini.sv
// Scoreboard bench for rift_core_mini: each program pushes its expected gp and retire count,
// and a monitor checks them when isEcall fires.
module tb_rift_core_mini;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ext_irq = 1'b0, tim_irq = 1'b0, sw_irq = 1'b0;
  logic        isEcall;
  logic [63:0] gp;

  rift_core_mini dut (
    .CLK              (CLK),
    .RST              (RST),
    .isExternInterrupt(ext_irq),
    .isRTimerInterrupt(tim_irq),
    .isSoftwvInterrupt(sw_irq),
    .isEcall          (isEcall),
    .gp               (gp)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [63:0] gp;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] prog_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;

  // Instructions retired since reset release.
  always @(posedge CLK) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RST && isEcall) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL ecall_unexpected: got isEcall=1 at cycle %0d, expected none", cyc);
      end else begin
        e = exp_q.pop_front();
        check("ecall_gp", gp, e.gp);
        check("ecall_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic itcm_write(input int i, input logic [31:0] w);
    if (i % 2 == 0) dut.ramEve[i/2] = w;
    else            dut.ramOdd[i/2] = w;
  endtask

  // Load prog_q at RESET_PC, expect ECALL with gp_exp after cyc_exp retirements.
  task automatic run(input string name, input logic [63:0] gp_exp, input int cyc_exp,
                     input int rst_at);
    exp_t e;
    RST = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < 32; i++) itcm_write(i, (i < prog_q.size()) ? prog_q[i] : 32'h0000_0013);
    e.gp  = gp_exp;
    e.cyc = 32'(cyc_exp);
    exp_q.push_back(e);
    RST = 1'b0;
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      @(negedge CLK);
      if (k == rst_at) begin
        RST = 1'b1;
        #1;
        check({name, "_rst_gp"}, gp, 64'd0);
        check({name, "_rst_ecall"}, 64'(isEcall), 64'd0);
        check({name, "_rst_pc"}, dut.pc_q, 64'h8000_0000);
        @(negedge CLK);
        RST = 1'b0;
      end
    end
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL %s_timeout: got no ECALL, expected gp=%h", name, gp_exp);
      exp_q.delete();
    end
  endtask

  initial begin
    dut.i_dtcm_B.ram[0] = 64'h1122_3344_5566_7788;  // byte address 0x80002008
    repeat (2) @(negedge CLK);
    check("reset_gp", gp, 64'd0);
    check("reset_ecall", 64'(isEcall), 64'd0);
    check("reset_pc", dut.pc_q, 64'h8000_0000);
    check("reset_halted", 64'(dut.halted_q), 64'd0);

    prog_q = {32'h0010_0193, 32'h0000_0073};
    run("pass_sig", 64'd1, 1, -1);
    repeat (3) @(negedge CLK);
    check("halt_pc_frozen", dut.pc_q, 64'h8000_0004);
    check("halt_ecall_low", 64'(isEcall), 64'd0);

    prog_q = {32'h0050_0193, 32'h0000_0073, 32'h0070_0193};
    run("fail_sig", 64'd5, 1, -1);
    repeat (3) @(negedge CLK);
    check("halt_no_write", gp, 64'd5);

    prog_q = {32'h0000_2097, 32'h0080_8093, 32'h0000_A183, 32'h0000_0073};
    run("lw", 64'h0000_0000_5566_7788, 3, -1);
    prog_q[2] = 32'h0000_B183;
    run("ld", 64'h1122_3344_5566_7788, 3, -1);
    prog_q[2] = 32'h0000_C183;
    run("lbu", 64'h0000_0000_0000_0088, 3, -1);
    prog_q[2] = 32'h0000_8183;
    run("lb", 64'hFFFF_FFFF_FFFF_FF88, 3, -1);
    prog_q[2] = 32'h0040_A183;
    run("lw_hi", 64'h0000_0000_1122_3344, 3, -1);

    prog_q = {32'h0000_2097, 32'h1234_5137, 32'h6781_0113, 32'h0201_1113,
              32'hFFF1_0113, 32'h0020_B823, 32'h0100_B183, 32'h0000_0073};
    run("sd_ld", 64'h1234_5677_FFFF_FFFF, 7, -1);
    check("sd_mem", dut.i_dtcm_A.ram[1], 64'h1234_5677_FFFF_FFFF);

    prog_q = {32'h0050_0193, 32'h0000_3183, 32'h0000_0073};
    run("ld_oor", 64'd0, 2, -1);

    prog_q = {32'h8000_0237, 32'hFFF2_019B, 32'h0000_0073};
    run("addiw", 64'h0000_0000_7FFF_FFFF, 2, -1);

    prog_q = {32'h0080_006F, 32'h0090_0193, 32'h0021_8193, 32'h0000_0073};
    run("jal", 64'd2, 2, -1);

    prog_q = {32'h0000_0193, 32'h00A0_0293, 32'h0011_8193, 32'hFE51_9EE3, 32'h0000_0073};
    run("loop", 64'd10, 22, -1);
    run("loop_midrst", 64'd10, 22, 5);

`ifdef RIFT_IRQ_EN
    RST = 1'b1;
    @(negedge CLK);
    prog_q = {32'h0000_0097, 32'h1000_8093, 32'h3050_9073, 32'h8000_0113,
              32'h3041_1073, 32'h3004_6073, 32'h0000_006F};
    for (int i = 0; i < 32; i++) itcm_write(i, (i < prog_q.size()) ? prog_q[i] : 32'h0000_0013);
    itcm_write(64, 32'h0070_0193);
    itcm_write(65, 32'h3020_0073);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    ext_irq = 1'b1;
    @(posedge CLK);
    #1;
    check("irq_pc", dut.pc_q, 64'h8000_0100);
    check("irq_mcause", dut.mcause_q, 64'h8000_0000_0000_000B);
    check("irq_mepc", dut.mepc_q, 64'h8000_0018);
    ext_irq = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("mret_pc", dut.pc_q, 64'h8000_0018);
    check("irq_handler_gp", gp, 64'd7);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
